instr_fetch_queue: RTL and testbench

//  Fetch stage directly upstream of the control/decode stage. Owns the PC.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_ring_buffer.sv | 78 +++++++
 rtl/instr_fetch_queue.sv | 102 ++++++++++
 tb/tb_instr_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, major opcodes and the
// fetch-queue entry record.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ring_buffer.sv
// DEPTH-entry ring of fetch slots. tail allocates on request, fill marks the
// next slot whose instruction has returned, head is the oldest slot for decode.
module fetch_ring_buffer
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_instr_i,
  input  logic            deq_i,
  input  logic            flush_i,
  output fetch_entry_t    head_entry_o,
  output logic [PW-1:0]   head_ptr_o,
  output logic [PW-1:0]   fill_ptr_o,
  output logic [PW-1:0]   tail_ptr_o
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] tail_q, tail_d;
  fetch_entry_t  entries_q [DEPTH];

  // NOTE: every _d gets its default before any branch, so no path can infer a latch.
  always_comb begin
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = tail_q;
      fill_d = tail_q;
    end else begin
      if (alloc_i) tail_d = tail_q + PW'(1);
      if (fill_i)  fill_d = fill_q + PW'(1);
      if (deq_i)   head_d = head_q + PW'(1);
    end
  end

  // NOTE: registers use <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which slots are live,
  // and an allocation always clears the slot's filled flag before it can be read.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i].filled <= 1'b0;
    end else begin
      if (alloc_i) begin
        entries_q[tail_q[PW-2:0]].pc     <= alloc_pc_i;
        entries_q[tail_q[PW-2:0]].filled <= 1'b0;
      end
      if (fill_i) begin
        entries_q[fill_q[PW-2:0]].instr  <= fill_instr_i;
        entries_q[fill_q[PW-2:0]].filled <= 1'b1;
      end
    end
  end

  assign head_entry_o = entries_q[head_q[PW-2:0]];
  assign head_ptr_o   = head_q;
  assign fill_ptr_o   = fill_q;
  assign tail_ptr_o   = tail_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues in-order word fetches under a credit limit,
// and drops responses that belong to requests flushed by a redirect.
module instr_fetch_queue
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [XLEN-1:0]          imem_rsp_data,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_target,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [XLEN-1:0]          dec_instr,
  output logic [XLEN-1:0]          dec_pc,
  output logic [XLEN-1:0]          dec_pc_plus4,
  output logic [6:0]               dec_op,
  output logic [2:0]               dec_funct3,
  output logic                     dec_funct7,
  output logic [$clog2(DEPTH):0]   busy_cnt
);

  localparam int            PW      = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]   head_ptr, fill_ptr, tail_ptr;
  logic [PW-1:0]   alloc_cnt, pending, drop_total;
  fetch_entry_t    head_entry;
  logic            req_fire, rsp_fill, deq;

  assign alloc_cnt  = tail_ptr - head_ptr;
  assign pending    = tail_ptr - fill_ptr;
  assign drop_total = drop_cnt_q + pending;
  assign busy_cnt   = alloc_cnt + drop_cnt_q;

  // Dropped-but-outstanding requests still hold a credit until their response returns.
  assign imem_req_valid = rst_n & ~redirect & (busy_cnt < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_fill = rst_n & imem_rsp_valid & ~redirect & (drop_cnt_q == '0) & (pending != '0);

  assign dec_valid = rst_n & head_entry.filled & (head_ptr != tail_ptr);
  assign deq       = dec_valid & dec_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      fetch_pc_d = redirect_target & ~XLEN'(3);
      // Every unfilled slot becomes a pending drop; a response arriving now is one of them.
      drop_cnt_d = (imem_rsp_valid && drop_total != '0) ? drop_total - PW'(1) : drop_total;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_i      (req_fire),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (rsp_fill),
    .fill_instr_i (imem_rsp_data),
    .deq_i        (deq),
    .flush_i      (redirect),
    .head_entry_o (head_entry),
    .head_ptr_o   (head_ptr),
    .fill_ptr_o   (fill_ptr),
    .tail_ptr_o   (tail_ptr)
  );

  assign dec_instr    = head_entry.instr;
  assign dec_pc       = head_entry.pc;
  assign dec_pc_plus4 = head_entry.pc + XLEN'(4);
  assign dec_op       = head_entry.instr[6:0];
  assign dec_funct3   = head_entry.instr[14:12];
  assign dec_funct7   = head_entry.instr[30];

  rsp_without_request_a : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (drop_cnt_q != '0 || pending != '0));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a vector table for steady fetch, credit
// back-pressure and redirect drops, plus hand sequences for the multi-cycle corners.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_ready = 1'b0, dec_ready = 1'b0, redirect = 1'b0, rsp_en = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        dec_valid, dec_funct7;
  logic [31:0] dec_instr, dec_pc, dec_pc_plus4;
  logic [6:0]  dec_op;
  logic [2:0]  dec_funct3, busy_cnt;

  logic        h_req_ready = 1'b0, h_dec_ready = 1'b0, h_rsp_valid = 1'b0, h_redirect = 1'b0;
  logic [31:0] h_rsp_data = '0, h_redirect_target = '0;
  logic        h_req_valid, h_dec_valid, h_funct7;
  logic [31:0] h_req_addr, h_instr, h_pc, h_pc_plus4;
  logic [6:0]  h_op;
  logic [2:0]  h_funct3, h_busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_target(redirect_target),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_pc_plus4(dec_pc_plus4), .dec_op(dec_op), .dec_funct3(dec_funct3),
    .dec_funct7(dec_funct7), .busy_cnt(busy_cnt)
  );

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(h_req_valid), .imem_req_ready(h_req_ready), .imem_req_addr(h_req_addr),
    .imem_rsp_valid(h_rsp_valid), .imem_rsp_data(h_rsp_data),
    .redirect(h_redirect), .redirect_target(h_redirect_target),
    .dec_valid(h_dec_valid), .dec_ready(h_dec_ready), .dec_instr(h_instr), .dec_pc(h_pc),
    .dec_pc_plus4(h_pc_plus4), .dec_op(h_op), .dec_funct3(h_funct3),
    .dec_funct7(h_funct7), .busy_cnt(h_busy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h4000_5033;
  endfunction

  // Memory model for the main DUT: answers in order, one cycle after fire, while rsp_en is set.
  logic [31:0] pend_q[$];
  always begin : responder
    logic        fire_s;
    logic [31:0] addr_s;
    @(negedge clk);
    fire_s = imem_req_valid & req_ready;
    addr_s = imem_req_addr;
    if (!rst_n) begin
      pend_q.delete();
      fire_s = 1'b0;
    end
    @(posedge clk);
    #2;
    if (fire_s) pend_q.push_back(addr_s);
    if (rsp_en && pend_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] epc);
    logic [31:0] w;
    w = mem_word(epc);
    check({tag, " dec_valid"}, 32'(dec_valid), 32'(1'b1));
    check({tag, " dec_pc"}, dec_pc, epc);
    check({tag, " dec_instr"}, dec_instr, w);
    check({tag, " dec_pc_plus4"}, dec_pc_plus4, epc + 32'd4);
    check({tag, " dec_op"}, 32'(dec_op), 32'(w[6:0]));
    check({tag, " dec_funct3"}, 32'(dec_funct3), 32'(w[14:12]));
    check({tag, " dec_funct7"}, 32'(dec_funct7), 32'(w[30]));
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic cyc(input logic rst, input logic rdy, input logic drdy, input logic redir,
                     input logic [31:0] tgt, input logic en);
    start_cycle();
    rst_n = rst; req_ready = rdy; dec_ready = drdy; redirect = redir;
    redirect_target = tgt; rsp_en = en;
    settle();
  endtask

  typedef struct {
    logic        rst, rdy, drdy, redir, en;
    logic [31:0] tgt;
    logic        ev, edv;
    logic [31:0] ea, epc;
    logic [2:0]  eb;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int rst, input int rdy, input int drdy, input int redir, input int tgt,
                     input int en, input int ev, input int ea, input int edv, input int epc,
                     input int eb);
    vec_t v;
    v.rst = 1'(rst); v.rdy = 1'(rdy); v.drdy = 1'(drdy); v.redir = 1'(redir);
    v.tgt = 32'(tgt); v.en = 1'(en); v.ev = 1'(ev); v.ea = 32'(ea);
    v.edv = 1'(edv); v.epc = 32'(epc); v.eb = 3'(eb);
    vq.push_back(v);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin : main
    //  rst rdy drdy rd tgt   en | v  addr   dv pc     busy
    // steady fetch, 1-cycle latency
    add(1, 1, 1, 0, 0,     1,   1, 'h0,   0, 0,     0);
    add(1, 1, 1, 0, 0,     1,   1, 'h4,   0, 0,     1);
    add(1, 1, 1, 0, 0,     1,   1, 'h8,   1, 'h0,   2);
    add(1, 1, 1, 0, 0,     1,   1, 'hC,   1, 'h4,   2);
    add(1, 1, 1, 0, 0,     1,   1, 'h10,  1, 'h8,   2);
    add(0, 1, 0, 0, 0,     1,   0, 0,     0, 0,     2);
    // decode stalled: credit limit, one deq frees exactly one fire
    add(1, 1, 0, 0, 0,     1,   1, 'h0,   0, 0,     0);
    add(1, 1, 0, 0, 0,     1,   1, 'h4,   0, 0,     1);
    add(1, 1, 0, 0, 0,     1,   1, 'h8,   1, 'h0,   2);
    add(1, 1, 0, 0, 0,     1,   1, 'hC,   1, 'h0,   3);
    add(1, 1, 0, 0, 0,     1,   0, 0,     1, 'h0,   4);
    add(1, 1, 1, 0, 0,     1,   0, 0,     1, 'h0,   4);
    add(1, 1, 0, 0, 0,     1,   1, 'h10,  1, 'h4,   3);
    add(1, 1, 0, 0, 0,     1,   0, 0,     1, 'h4,   4);
    add(1, 1, 0, 0, 0,     1,   0, 0,     1, 'h4,   4);
    add(0, 1, 0, 0, 0,     0,   0, 0,     0, 0,     4);
    // two outstanding, redirect to 0x103, stale responses dropped
    add(1, 1, 0, 0, 0,     0,   1, 'h0,   0, 0,     0);
    add(1, 1, 0, 0, 0,     0,   1, 'h4,   0, 0,     1);
    add(1, 1, 0, 1, 'h103, 0,   0, 0,     0, 0,     2);
    add(1, 1, 0, 0, 0,     1,   1, 'h100, 0, 0,     2);
    add(1, 1, 0, 0, 0,     1,   1, 'h104, 0, 0,     2);
    add(1, 1, 0, 0, 0,     1,   1, 'h108, 0, 0,     2);
    add(1, 1, 0, 0, 0,     1,   1, 'h10C, 1, 'h100, 3);
    add(1, 1, 0, 0, 0,     1,   0, 0,     1, 'h100, 4);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      vec_t v;
      string tag;
      v = vq[i];
      tag = $sformatf("vec%0d", i);
      cyc(v.rst, v.rdy, v.drdy, v.redir, v.tgt, v.en);
      check({tag, " req_valid"}, 32'(imem_req_valid), 32'(v.ev));
      if (v.ev) check({tag, " req_addr"}, imem_req_addr, v.ea);
      check({tag, " dec_valid"}, 32'(dec_valid), 32'(v.edv));
      if (v.edv) chk_head(tag, v.epc);
      check({tag, " busy_cnt"}, 32'(busy_cnt), 32'(v.eb));
    end

    // redirect coinciding with a deq and a response
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 1);
    check("rd_deq c0 addr", imem_req_addr, 32'h0);
    cyc(1, 1, 1, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 1);
    chk_head("rd_deq c2", 32'h0);
    cyc(1, 1, 1, 1, 32'h200, 1);
    check("rd_deq c3 rsp_present", 32'(imem_rsp_valid), 32'(1'b1));
    check("rd_deq c3 req_valid", 32'(imem_req_valid), 32'(1'b0));
    chk_head("rd_deq c3", 32'h4);
    check("rd_deq c3 busy", 32'(busy_cnt), 32'd2);
    cyc(1, 1, 1, 0, 0, 1);
    check("rd_deq c4 req_valid", 32'(imem_req_valid), 32'(1'b1));
    check("rd_deq c4 addr", imem_req_addr, 32'h200);
    check("rd_deq c4 busy", 32'(busy_cnt), 32'd0);
    check("rd_deq c4 dec_valid", 32'(dec_valid), 32'(1'b0));
    cyc(1, 1, 1, 0, 0, 1);
    check("rd_deq c5 addr", imem_req_addr, 32'h204);
    check("rd_deq c5 busy", 32'(busy_cnt), 32'd1);
    cyc(1, 1, 1, 0, 0, 1);
    chk_head("rd_deq c6", 32'h200);
    check("rd_deq c6 busy", 32'(busy_cnt), 32'd2);
    cyc(1, 1, 1, 0, 0, 1);
    chk_head("rd_deq c7", 32'h204);

    // reset with two requests in flight
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    check("mid_rst c0 addr", imem_req_addr, 32'h0);
    cyc(1, 1, 1, 0, 0, 0);
    check("mid_rst c1 busy", 32'(busy_cnt), 32'd1);
    cyc(0, 1, 1, 0, 0, 0);
    check("mid_rst in-reset req_valid", 32'(imem_req_valid), 32'(1'b0));
    check("mid_rst in-reset dec_valid", 32'(dec_valid), 32'(1'b0));
    cyc(1, 1, 1, 0, 0, 1);
    check("mid_rst r0 req_valid", 32'(imem_req_valid), 32'(1'b1));
    check("mid_rst r0 addr", imem_req_addr, 32'h0);
    check("mid_rst r0 busy", 32'(busy_cnt), 32'd0);
    check("mid_rst r0 rsp_present", 32'(imem_rsp_valid), 32'(1'b0));
    cyc(1, 1, 1, 0, 0, 1);
    check("mid_rst r1 addr", imem_req_addr, 32'h4);
    check("mid_rst r1 dec_valid", 32'(dec_valid), 32'(1'b0));
    cyc(1, 1, 1, 0, 0, 1);
    chk_head("mid_rst r2", 32'h0);
    check("mid_rst r2 busy", 32'(busy_cnt), 32'd2);
    cyc(1, 1, 1, 0, 0, 1);
    chk_head("mid_rst r3", 32'h4);

    // address wrap from RESET_PC = 0xFFFF_FFF8
    cyc(0, 0, 0, 0, 0, 0);
    start_cycle();
    rst_n = 1'b1; h_req_ready = 1'b1;
    settle();
    check("wrap c0 req_valid", 32'(h_req_valid), 32'(1'b1));
    check("wrap c0 addr", h_req_addr, 32'hFFFF_FFF8);
    start_cycle();
    h_rsp_valid = 1'b1; h_rsp_data = mem_word(32'hFFFF_FFF8);
    settle();
    check("wrap c1 addr", h_req_addr, 32'hFFFF_FFFC);
    check("wrap c1 dec_valid", 32'(h_dec_valid), 32'(1'b0));
    start_cycle();
    h_rsp_data = mem_word(32'hFFFF_FFFC); h_dec_ready = 1'b1;
    settle();
    check("wrap c2 addr", h_req_addr, 32'h0);
    check("wrap c2 dec_valid", 32'(h_dec_valid), 32'(1'b1));
    check("wrap c2 dec_pc", h_pc, 32'hFFFF_FFF8);
    check("wrap c2 dec_pc_plus4", h_pc_plus4, 32'hFFFF_FFFC);
    start_cycle();
    h_req_ready = 1'b0; h_dec_ready = 1'b0; h_rsp_data = mem_word(32'h0);
    settle();
    check("wrap c3 dec_pc", h_pc, 32'hFFFF_FFFC);
    check("wrap c3 dec_pc_plus4", h_pc_plus4, 32'h0);
    check("wrap c3 dec_instr", h_instr, mem_word(32'hFFFF_FFFC));
    check("wrap c3 busy", 32'(h_busy), 32'd2);
    start_cycle();
    h_rsp_valid = 1'b0;
    settle();
    check("wrap c4 dec_pc", h_pc, 32'hFFFF_FFFC);
    check("wrap c4 busy", 32'(h_busy), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
